// File: rtl/router_pkt_fifo.sv
// Packet-aware output FIFO for one router destination channel: stores {sop, data},
// tracks packet boundaries from the header length on the read side, and can auto-flush on read starvation.
module router_pkt_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int TIMEOUT   = 30
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     soft_rst,
    input  logic                     we,
    input  logic                     sop,
    input  logic [DATA_W-1:0]        din,
    input  logic                     re,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    output logic                     dout_sop,
    output logic                     rd_eop,
    output logic [DATA_W-2:0]        rd_remain,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic                     tmo
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = DATA_W - 1;
    localparam logic [AW:0]  PTR_ONE = (AW+1)'(1);
    localparam logic [RW-1:0] REM_ONE = RW'(1);
    localparam logic [31:0]  AF_U = AF_THRESH;

    logic [DATA_W:0]     mem [DEPTH];
    logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [RW-1:0]       rd_remain_q, rd_remain_d;
    logic [DATA_W-1:0]   dout_q;
    logic                dout_valid_q, dout_sop_q, rd_eop_q, rd_eop_d, ovf_q;
    logic [DATA_W:0]     rd_word;
    logic                tmo_flush, flush, wr_acc, rd_acc;

    assign level       = wr_ptr_q - rd_ptr_q;
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign almost_full = (32'(level) >= AF_U);

    assign flush   = soft_rst || tmo_flush;
    assign wr_acc  = we && !full && !flush;
    assign rd_acc  = re && !empty && !flush;
    assign rd_word = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_remain_d = rd_remain_q;
        rd_eop_d    = 1'b0;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            rd_remain_d = '0;
        end else begin
            if (wr_acc)
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                // Header reloads the count with payload length plus the trailing parity word
                if (rd_word[DATA_W])
                    rd_remain_d = RW'(rd_word[DATA_W-1:2]) + REM_ONE;
                else if (rd_remain_q != '0) begin
                    rd_remain_d = rd_remain_q - REM_ONE;
                    rd_eop_d    = (rd_remain_q == REM_ONE);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_remain_q  <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_sop_q   <= 1'b0;
            rd_eop_q     <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_remain_q  <= rd_remain_d;
            rd_eop_q     <= rd_eop_d;
            ovf_q        <= we && full;
            dout_valid_q <= rd_acc;
            dout_sop_q   <= rd_acc && rd_word[DATA_W];
            if (flush)
                dout_q <= '0;
            else if (rd_acc)
                dout_q <= rd_word[DATA_W-1:0];
        end
    end

    // Storage is never cleared; only the pointers decide what is valid
    always_ff @(posedge clk) begin
        if (rstn && wr_acc)
            mem[wr_ptr_q[AW-1:0]] <= {sop, din};
    end

    generate
        if (TIMEOUT > 0) begin : g_tmo
            localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            logic [TW-1:0] tmo_cnt_q;
            logic          tmo_q, stall;

            assign stall     = !empty && !re;
            assign tmo_flush = stall && (tmo_cnt_q == TW'(TIMEOUT - 1));
            assign tmo       = tmo_q;

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    tmo_cnt_q <= '0;
                    tmo_q     <= 1'b0;
                end else begin
                    tmo_q <= tmo_flush;
                    if (soft_rst || tmo_flush || !stall)
                        tmo_cnt_q <= '0;
                    else
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                end
            end
        end else begin : g_no_tmo
            assign tmo_flush = 1'b0;
            assign tmo       = 1'b0;
        end
    endgenerate

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_sop   = dout_sop_q;
    assign rd_eop     = rd_eop_q;
    assign rd_remain  = rd_remain_q;
    assign ovf        = ovf_q;
endmodule

// File: tb/tb_router_pkt_fifo.sv
// Self-checking bench for router_pkt_fifo: directed scenarios plus randomized traffic,
// all compared every cycle against a queue-based packet FIFO model.
module tb_router_pkt_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF     = 14;
    localparam int TMO    = 30;

    logic              clk = 1'b0;
    logic              rstn = 1'b0, soft_rst = 1'b0, we = 1'b0, sop = 1'b0, re = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic [DATA_W-1:0] dout;
    logic              dout_valid, dout_sop, rd_eop, full, empty, almost_full, ovf, tmo;
    logic [DATA_W-2:0] rd_remain;
    logic [4:0]        level;

    router_pkt_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn), .soft_rst(soft_rst), .we(we), .sop(sop), .din(din), .re(re),
        .dout(dout), .dout_valid(dout_valid), .dout_sop(dout_sop), .rd_eop(rd_eop),
        .rd_remain(rd_remain), .full(full), .empty(empty), .almost_full(almost_full),
        .level(level), .ovf(ovf), .tmo(tmo)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;

    // Reference model: a queue of {sop,data} words plus packet/stall bookkeeping
    logic [DATA_W:0]   mq[$];
    int                m_remain, m_stall;
    logic [DATA_W-1:0] m_dout;
    bit                m_dv, m_dsop, m_eop, m_ovf, m_tmo;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_remain = 0; m_stall = 0; m_dout = '0;
        m_dv = 0; m_dsop = 0; m_eop = 0; m_ovf = 0; m_tmo = 0;
    endtask

    task automatic model_update(input bit w, input bit s, input logic [DATA_W-1:0] d,
                                input bit r, input bit sr);
        bit full_m, empty_m, rd_ok, stall, hit;
        logic [DATA_W:0] e;
        full_m  = (mq.size() == DEPTH);
        empty_m = (mq.size() == 0);
        rd_ok   = r && !empty_m;
        stall   = !empty_m && !rd_ok;
        hit     = stall && (m_stall == TMO - 1);
        m_ovf = w && full_m;
        m_tmo = hit;
        m_dv = 0; m_dsop = 0; m_eop = 0;
        if (sr || hit) begin
            mq.delete();
            m_remain = 0; m_dout = '0; m_stall = 0;
        end else begin
            if (rd_ok) begin
                e = mq.pop_front();
                m_dout = e[DATA_W-1:0];
                m_dv   = 1;
                m_dsop = e[DATA_W];
                if (e[DATA_W])
                    m_remain = int'(e[DATA_W-1:2]) + 1;
                else if (m_remain > 0) begin
                    m_remain--;
                    m_eop = (m_remain == 0);
                end
            end
            if (w && !full_m)
                mq.push_back({s, d});
            m_stall = stall ? m_stall + 1 : 0;
        end
    endtask

    task automatic compare_all();
        check_eq("dout", dout, m_dout);
        check_eq("dout_valid", dout_valid, m_dv);
        check_eq("dout_sop", dout_sop, m_dsop);
        check_eq("rd_eop", rd_eop, m_eop);
        check_eq("rd_remain", rd_remain, m_remain);
        check_eq("level", level, mq.size());
        check_eq("full", full, mq.size() == DEPTH);
        check_eq("empty", empty, mq.size() == 0);
        check_eq("almost_full", almost_full, mq.size() >= AF);
        check_eq("ovf", ovf, m_ovf);
        check_eq("tmo", tmo, m_tmo);
    endtask

    task automatic step(input bit w, input bit s, input logic [DATA_W-1:0] d,
                        input bit r, input bit sr);
        we = w; sop = s; din = d; re = r; soft_rst = sr;
        @(posedge clk);
        cyc++;
        model_update(w, s, d, r, sr);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0);
    endtask

    logic [7:0] pkt_words [5];
    int         pkt_rem [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "bench timed out");
    end

    initial begin
        pkt_words[0] = 8'h0D; pkt_words[1] = 8'hA1; pkt_words[2] = 8'hA2;
        pkt_words[3] = 8'hA3; pkt_words[4] = 8'h5F;
        pkt_rem[0] = 4; pkt_rem[1] = 3; pkt_rem[2] = 2; pkt_rem[3] = 1; pkt_rem[4] = 0;

        // Reset
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        check_eq("rst_empty", empty, 1);
        rstn = 1'b1;

        // One packet, read back-to-back
        for (int i = 0; i < 5; i++) step(1, i == 0, pkt_words[i], 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, '0, 1, 0);
            check_eq("pkt_dout", dout, pkt_words[i]);
            check_eq("pkt_remain", rd_remain, pkt_rem[i]);
            check_eq("pkt_sop", dout_sop, i == 0);
            check_eq("pkt_eop", rd_eop, i == 4);
        end
        idle();
        check_eq("pkt_idle_valid", dout_valid, 0);

        // Fill past full
        for (int i = 1; i <= 17; i++) begin
            step(1, 0, 8'(i * 7 + 3), 0, 0);
            if (i == 13) check_eq("af_13", almost_full, 0);
            if (i == 14) check_eq("af_14", almost_full, 1);
            if (i == 16) begin
                check_eq("full_16", full, 1);
                check_eq("level_16", level, 16);
                check_eq("ovf_16", ovf, 0);
            end
            if (i == 17) check_eq("ovf_17", ovf, 1);
        end
        idle();
        check_eq("ovf_once", ovf, 0);

        // Read+write while full
        step(1, 0, 8'hEE, 1, 0);
        check_eq("rw_full_level", level, 15);
        check_eq("rw_full_ovf", ovf, 1);
        check_eq("rw_full_dout", dout, 8'd10);
        for (int i = 0; i < 15; i++) step(0, 0, '0, 1, 0);
        check_eq("drained", empty, 1);

        // Read+write while empty: no fall-through
        step(1, 0, 8'h3C, 1, 0);
        check_eq("rw_empty_level", level, 1);
        check_eq("rw_empty_valid", dout_valid, 0);
        step(0, 0, '0, 1, 0);
        check_eq("rw_empty_dout", dout, 8'h3C);

        // Streaming through pointer wrap
        for (int i = 0; i < 40; i++) step(1, 0, 8'($urandom), 1, 0);
        step(0, 0, '0, 1, 0);
        check_eq("stream_empty", empty, 1);

        // Timeout: 29 stalled cycles survive, 30 flush
        step(1, 0, 8'h11, 0, 0);
        step(1, 0, 8'h22, 0, 0);
        for (int i = 0; i < 28; i++) idle();
        check_eq("tmo_29", tmo, 0);
        step(0, 0, '0, 1, 0);
        check_eq("tmo_read", dout, 8'h11);
        check_eq("tmo_read_level", level, 1);
        for (int i = 0; i < 29; i++) idle();
        check_eq("tmo_pre", tmo, 0);
        check_eq("tmo_pre_level", level, 1);
        idle();
        check_eq("tmo_pulse", tmo, 1);
        check_eq("tmo_empty", empty, 1);
        check_eq("tmo_level", level, 0);
        idle();
        check_eq("tmo_once", tmo, 0);

        // soft_rst mid-packet with a concurrent write
        for (int i = 0; i < 5; i++) step(1, i == 0, pkt_words[i], 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, 0);
        check_eq("srst_pre_remain", rd_remain, 2);
        step(1, 0, 8'h77, 0, 1);
        check_eq("srst_level", level, 0);
        check_eq("srst_remain", rd_remain, 0);
        check_eq("srst_dout", dout, 0);
        idle();
        check_eq("srst_wr_dropped", empty, 1);

        // Randomized traffic with per-phase biases
        for (int ph = 0; ph < 10; ph++) begin
            int pw, pr;
            pw = $urandom_range(20, 90);
            pr = $urandom_range(5, 90);
            for (int i = 0; i < 200; i++)
                step($urandom_range(0, 99) < pw, $urandom_range(0, 3) == 0, 8'($urandom),
                     $urandom_range(0, 99) < pr, $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
